// File: rtl/mcycle_param.sv
// rtl/mcycle_param.sv - parametrised multi-cycle shift-add multiply / restoring divide unit
module mcycle_param #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q;
  logic               is_div_q, neg_quo_q, neg_rem_q, dz_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   res1_d, res2_d;

  logic               signed_op, div_op, op1_neg, op2_neg;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum, shifted;
  logic               ge;
  logic [2*WIDTH-1:0] prod;

  assign signed_op = ~MCycleOp[0];
  assign div_op    = MCycleOp[1];
  assign op1_neg   = signed_op & Operand1[WIDTH-1];
  assign op2_neg   = signed_op & Operand2[WIDTH-1];
  assign mag1      = op1_neg ? -Operand1 : Operand1;
  assign mag2      = op2_neg ? -Operand2 : Operand2;

  // Multiply: multiplier sits in acc low half and shifts out LSB first.
  // Divide: dividend sits in acc low half, quotient bits shift in behind it.
  always_comb begin
    addend  = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    shifted = {rem_q, acc_q[WIDTH-1]};
    ge      = shifted >= {1'b0, opnd_q};
    acc_d   = {sum, acc_q[WIDTH-1:1]};
    rem_d   = rem_q;
    if (is_div_q) begin
      acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ge};
      rem_d = ge ? (shifted[WIDTH-1:0] - opnd_q) : shifted[WIDTH-1:0];
    end
  end

  always_comb begin
    prod   = neg_quo_q ? -acc_q : acc_q;
    res1_d = prod[WIDTH-1:0];
    res2_d = prod[2*WIDTH-1:WIDTH];
    if (dz_q) begin
      res1_d = {WIDTH{1'b1}};
      res2_d = acc_q[WIDTH-1:0];
    end else if (is_div_q) begin
      res1_d = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      res2_d = neg_rem_q ? -rem_q : rem_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      Result1   <= '0;
      Result2   <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            is_div_q  <= div_op;
            neg_quo_q <= op1_neg ^ op2_neg;
            neg_rem_q <= op1_neg;
            rem_q     <= '0;
            cnt_q     <= '0;
            Busy      <= 1'b1;
            // Zero divisor skips the iterations; raw dividend is kept for Result2.
            if (div_op && (Operand2 == '0)) begin
              dz_q    <= 1'b1;
              acc_q   <= {{WIDTH{1'b0}}, Operand1};
              state_q <= FIX;
            end else begin
              dz_q    <= 1'b0;
              opnd_q  <= div_op ? mag2 : mag1;
              acc_q   <= {{WIDTH{1'b0}}, (div_op ? mag1 : mag2)};
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          Result1   <= res1_d;
          Result2   <= res2_d;
          DivByZero <= dz_q;
          Done      <= 1'b1;
          Busy      <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_param.sv
// tb/tb_mcycle_param.sv - scoreboard bench for mcycle_param at WIDTH 4 and 32
module tb_mcycle_param;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        dz;
    int          at;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start4, start32;
  logic [1:0]  op4, op32;
  logic [3:0]  a4, b4;
  logic [31:0] a32, b32;
  logic [3:0]  r1_4, r2_4;
  logic [31:0] r1_32, r2_32;
  logic        busy4, done4, dz4, busy32, done32, dz32;

  exp_t q4[$];
  exp_t q32[$];
  exp_t e4, e32;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  mcycle_param #(.WIDTH(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .Start(start4), .MCycleOp(op4),
    .Operand1(a4), .Operand2(b4), .Result1(r1_4), .Result2(r2_4),
    .Busy(busy4), .Done(done4), .DivByZero(dz4)
  );

  mcycle_param #(.WIDTH(32)) dut32 (
    .CLK(CLK), .RESET(RESET), .Start(start32), .MCycleOp(op32),
    .Operand1(a32), .Operand2(b32), .Result1(r1_32), .Result2(r2_32),
    .Busy(busy32), .Done(done32), .DivByZero(dz32)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation per Done strobe.
  always @(negedge CLK) begin
    if (done4) begin
      if (q4.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL w4_spurious_done: Done high with no operation outstanding (cycle %0d)", cyc);
      end else begin
        e4 = q4.pop_front();
        chk("w4_result1", 64'(r1_4), 64'(e4.r1[3:0]));
        chk("w4_result2", 64'(r2_4), 64'(e4.r2[3:0]));
        chk("w4_divbyzero", 64'(dz4), 64'(e4.dz));
        chk("w4_done_cycle", 64'(cyc), 64'(e4.at));
        chk("w4_busy_with_done", 64'(busy4), 64'(0));
      end
    end
    if (done32) begin
      if (q32.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL w32_spurious_done: Done high with no operation outstanding (cycle %0d)", cyc);
      end else begin
        e32 = q32.pop_front();
        chk("w32_result1", 64'(r1_32), 64'(e32.r1));
        chk("w32_result2", 64'(r2_32), 64'(e32.r2));
        chk("w32_divbyzero", 64'(dz32), 64'(e32.dz));
        chk("w32_done_cycle", 64'(cyc), 64'(e32.at));
        chk("w32_busy_with_done", 64'(busy32), 64'(0));
      end
    end
  end

  // Issue one op with Start held; operands are scrambled while busy and must be ignored.
  task automatic run4(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] r1, input logic [3:0] r2, input logic dz, input int lat);
    bit seen = 0;
    op4 = op; a4 = a; b4 = b; start4 = 1'b1;
    q4.push_back('{32'(r1), 32'(r2), dz, cyc + 1 + lat});
    @(negedge CLK);
    for (int i = 0; i < 20 && !seen; i++) begin
      op4 = 2'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
      @(negedge CLK);
      seen = done4;
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL w4_timeout: no Done within 20 cycles for op %b %h,%h", op, a, b);
      q4.delete();
    end
  endtask

  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r1, input logic [31:0] r2, input logic dz, input int lat);
    bit seen = 0;
    op32 = op; a32 = a; b32 = b; start32 = 1'b1;
    q32.push_back('{r1, r2, dz, cyc + 1 + lat});
    @(negedge CLK);
    for (int i = 0; i < 50 && !seen; i++) begin
      op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
      @(negedge CLK);
      seen = done32;
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL w32_timeout: no Done within 50 cycles for op %b %h,%h", op, a, b);
      q32.delete();
    end
  endtask

  initial begin
    RESET = 1'b1; start4 = 1'b0; start32 = 1'b0;
    op4 = '0; a4 = '0; b4 = '0; op32 = '0; a32 = '0; b32 = '0;
    repeat (2) @(negedge CLK);
    chk("reset_result1", 64'(r1_4), 64'(0));
    chk("reset_result2", 64'(r2_4), 64'(0));
    chk("reset_flags", 64'({busy4, done4, dz4}), 64'(0));
    chk("reset_w32", 64'({r1_32 | r2_32, busy32, done32, dz32}), 64'(0));
    RESET = 1'b0;
    @(negedge CLK);

    // WIDTH=4, back-to-back: op, a, b, Result1, Result2, DivByZero, latency
    run4(2'b10, 4'h9, 4'h3, 4'hE, 4'hF, 1'b0, 5);
    run4(2'b00, 4'h9, 4'h7, 4'hF, 4'hC, 1'b0, 5);
    run4(2'b01, 4'h3, 4'h3, 4'h9, 4'h0, 1'b0, 5);
    run4(2'b11, 4'hE, 4'hF, 4'h0, 4'hE, 1'b0, 5);
    run4(2'b11, 4'h5, 4'h0, 4'hF, 4'h5, 1'b1, 1);
    run4(2'b10, 4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 5);
    run4(2'b00, 4'h8, 4'h8, 4'h0, 4'h4, 1'b0, 5);
    run4(2'b01, 4'hF, 4'hF, 4'h1, 4'hE, 1'b0, 5);
    run4(2'b10, 4'h7, 4'hE, 4'hD, 4'h1, 1'b0, 5);
    run4(2'b00, 4'h7, 4'hF, 4'h9, 4'hF, 1'b0, 5);
    run4(2'b10, 4'hE, 4'h7, 4'h0, 4'hE, 1'b0, 5);
    run4(2'b11, 4'hF, 4'h1, 4'hF, 4'h0, 1'b0, 5);
    run4(2'b10, 4'h9, 4'h0, 4'hF, 4'h9, 1'b1, 1);

    // Abort an op with RESET at RUN iteration 2; results must hold until then.
    op4 = 2'b01; a4 = 4'h3; b4 = 4'h3; start4 = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("hold_result1_busy", 64'(r1_4), 64'(4'hF));
    chk("hold_divbyzero_busy", 64'(dz4), 64'(1));
    @(negedge CLK);
    RESET = 1'b1; start4 = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    chk("abort_results", 64'({r1_4, r2_4}), 64'(0));
    chk("abort_flags", 64'({busy4, done4, dz4}), 64'(0));
    repeat (8) @(negedge CLK);
    chk("abort_stays_idle", 64'({busy4, done4}), 64'(0));

    run4(2'b00, 4'h8, 4'h7, 4'h8, 4'hC, 1'b0, 5);
    run4(2'b01, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 5);
    start4 = 1'b0;

    // WIDTH=32 extremes
    run32(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 33);
    run32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33);
    run32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 33);
    run32(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0, 33);
    run32(2'b10, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
    run32(2'b11, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1);
    run32(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 32'h3FFF_FFFF, 1'b0, 33);
    run32(2'b01, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0, 33);
    start32 = 1'b0;

    repeat (5) @(negedge CLK);
    chk("w4_queue_drained", 64'(q4.size()), 64'(0));
    chk("w32_queue_drained", 64'(q32.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
